// File: rtl/demux_reg9_pkg.sv
// Shared constants and FSM encoding for the 9-slot frame-loading demux.
package demux_reg9_pkg;

  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned N_SLOTS  = 9;
  localparam int unsigned N_SHADOW = N_SLOTS - 1;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned SH_W     = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/demux_reg9_frame_timeout_cnt.sv
// Loadable down-counter that flags the idle cycle on which a frame times out.
module frame_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Remaining idle budget: reloaded on activity, decremented on idle cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(TIMEOUT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Expires on the idle cycle that consumes the last unit of budget.
  assign expire_c = (TIMEOUT != 0) && en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/demux_reg9.sv
// Streams a 9-byte frame into a shadow bank and publishes it atomically.
module demux_reg9
  import demux_reg9_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             wr_en_i,
  input  logic [DW-1:0]    data_i,
  output logic [DW-1:0]    out_0,
  output logic [DW-1:0]    out_1,
  output logic [DW-1:0]    out_2,
  output logic [DW-1:0]    out_3,
  output logic [DW-1:0]    out_4,
  output logic [DW-1:0]    out_5,
  output logic [DW-1:0]    out_6,
  output logic [DW-1:0]    out_7,
  output logic [DW-1:0]    out_8,
  output logic [IDX_W-1:0] sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_t           state_q;
  logic [DW-1:0]    shadow_q [N_SHADOW];
  logic [DW-1:0]    pub_q    [N_SLOTS];
  logic [IDX_W-1:0] sel_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic tmo_clr;
  logic tmo_load;
  logic tmo_en;
  logic tmo_expire_c;

  // Timeout control: idle in IDLE, rearmed by any start or write, counts idle LOAD cycles.
  always_comb begin
    tmo_clr  = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;
    if (state_q == IDLE) begin
      tmo_clr  = !start_i;
      tmo_load = start_i;
    end else begin
      tmo_load = start_i || wr_en_i;
      tmo_en   = !start_i && !wr_en_i;
    end
  end

  frame_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (tmo_clr),
    .load_i   (tmo_load),
    .en_i     (tmo_en),
    .expire_c (tmo_expire_c)
  );

  // Frame FSM: fills the shadow bank and publishes all slots on the last byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int j = 0; j < int'(N_SHADOW); j++) shadow_q[j] <= '0;
      for (int j = 0; j < int'(N_SLOTS); j++)  pub_q[j]    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            sel_q   <= '0;
            err_q   <= 1'b0;
          end else if (wr_en_i) begin
            err_q <= 1'b1;
          end
        end
        LOAD: begin
          if (start_i) begin
            sel_q <= '0;
            err_q <= 1'b1;
          end else if (wr_en_i) begin
            if (sel_q == LAST_IDX) begin
              for (int j = 0; j < int'(N_SHADOW); j++) pub_q[j] <= shadow_q[j];
              pub_q[N_SLOTS-1] <= data_i;
              done_q  <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              sel_q   <= '0;
            end else begin
              shadow_q[sel_q[SH_W-1:0]] <= data_i;
              sel_q <= sel_q + IDX_W'(1);
            end
          end else if (tmo_expire_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sel_q   <= '0;
        end
      endcase
    end
  end

  assign out_0  = pub_q[0];
  assign out_1  = pub_q[1];
  assign out_2  = pub_q[2];
  assign out_3  = pub_q[3];
  assign out_4  = pub_q[4];
  assign out_5  = pub_q[5];
  assign out_6  = pub_q[6];
  assign out_7  = pub_q[7];
  assign out_8  = pub_q[8];
  assign sel_o  = sel_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_demux_reg9.sv
// Scoreboard bench for demux_reg9: expected frames queued by stimulus, checked on done_o.
module tb_demux_reg9;

  typedef logic [8:0][7:0] frame_t;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic       start_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8;
  logic [3:0] sel_o;
  logic       busy_o, done_o, err_o;

  frame_t cur_frame;
  frame_t pub_exp;
  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  assign cur_frame = {out_8, out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0};

  demux_reg9 #(.DW(8), .TIMEOUT(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .wr_en_i (wr_en_i),
    .data_i  (data_i),
    .out_0   (out_0),
    .out_1   (out_1),
    .out_2   (out_2),
    .out_3   (out_3),
    .out_4   (out_4),
    .out_5   (out_5),
    .out_6   (out_6),
    .out_7   (out_7),
    .out_8   (out_8),
    .sel_o   (sel_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] base);
    frame_t f;
    for (int j = 0; j < 9; j++) f[j] = base + 8'(j);
    return f;
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_start();
    start_i = 1'b1;
    wr_en_i = 1'b0;
    cycle();
    start_i = 1'b0;
  endtask

  task automatic drive_write(input logic [7:0] d);
    wr_en_i = 1'b1;
    data_i  = d;
    cycle();
    wr_en_i = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] base);
    drive_start();
    check("err_clear_on_start", 32'(err_o), 32'd0);
    check("busy_after_start", 32'(busy_o), 32'd1);
    exp_q.push_back(mk(base));
    for (int j = 0; j < 9; j++) drive_write(base + 8'(j));
    pub_exp = mk(base);
  endtask

  task automatic check_pub(input string name);
    check(name, 32'(cur_frame[0]) ^ 32'(cur_frame[4]) << 8 ^ 32'(cur_frame[8]) << 16,
          32'(pub_exp[0]) ^ 32'(pub_exp[4]) << 8 ^ 32'(pub_exp[8]) << 16);
    for (int j = 0; j < 9; j++) check(name, 32'(cur_frame[j]), 32'(pub_exp[j]));
  endtask

  // Monitor: every done_o pulse must match the oldest queued frame.
  always @(negedge clk_i) begin
    if (rst_n_i && done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        for (int j = 0; j < 9; j++) check("frame_byte", 32'(cur_frame[j]), 32'(f[j]));
      end
    end
  end

  initial begin
    pub_exp = '0;
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_outs", 32'(cur_frame[0] | cur_frame[8]), 32'd0);
    check("rst_sel", 32'(sel_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    cycle();
    cycle();
    rst_n_i = 1'b1;
    cycle();

    // Basic frame 10..18
    run_frame(8'h10);
    check("done_pulse", 32'(done_o), 32'd1);
    check("busy_after_frame", 32'(busy_o), 32'd0);
    check("err_after_frame", 32'(err_o), 32'd0);
    check("sel_after_frame", 32'(sel_o), 32'd0);
    cycle();
    check("done_one_cycle", 32'(done_o), 32'd0);
    check_pub("pub_first");

    // Restart mid-frame
    drive_start();
    for (int j = 0; j < 4; j++) drive_write(8'hA0 + 8'(j));
    check("sel_partial", 32'(sel_o), 32'd4);
    drive_start();
    check("restart_err", 32'(err_o), 32'd1);
    check("restart_sel", 32'(sel_o), 32'd0);
    check("restart_busy", 32'(busy_o), 32'd1);
    check_pub("pub_after_restart");
    for (int j = 0; j < 4; j++) cycle();
    check("restart_timeout_busy", 32'(busy_o), 32'd0);
    run_frame(8'h00);
    check_pub("pub_second");

    // Write while idle
    drive_write(8'hFF);
    check("idle_wr_err", 32'(err_o), 32'd1);
    check("idle_wr_busy", 32'(busy_o), 32'd0);
    check_pub("pub_after_idle_wr");
    run_frame(8'h20);

    // Timeout after two writes
    drive_start();
    drive_write(8'h55);
    drive_write(8'h66);
    for (int j = 0; j < 3; j++) cycle();
    check("tmo_busy_before", 32'(busy_o), 32'd1);
    check("tmo_sel_before", 32'(sel_o), 32'd2);
    cycle();
    check("tmo_busy", 32'(busy_o), 32'd0);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_sel", 32'(sel_o), 32'd0);
    check_pub("pub_after_tmo");

    // Back-to-back frames
    run_frame(8'h01);
    run_frame(8'h11);
    cycle();
    check_pub("pub_b2b");
    check("b2b_err", 32'(err_o), 32'd0);

    // Asynchronous reset mid-frame
    drive_start();
    for (int j = 0; j < 5; j++) drive_write(8'hC0 + 8'(j));
    check("pre_rst_sel", 32'(sel_o), 32'd5);
    #2 rst_n_i = 1'b0;
    #1;
    pub_exp = '0;
    check_pub("async_rst_outs");
    check("async_rst_sel", 32'(sel_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_done", 32'(done_o), 32'd0);
    cycle();
    rst_n_i = 1'b1;
    cycle();
    run_frame(8'h30);
    cycle();
    check_pub("pub_after_rst");

    cycle();
    cycle();
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_reg9.md
# demux_reg9

Frame-loading demultiplexer with a 9 × 8-bit register bank. It is the write-side counterpart of the 9:1 registered byte selector. Upstream logic (RTC interface / config sequencer) streams a 9-byte frame over one byte bus. The block distributes the bytes into a shadow bank and publishes all 9 slots atomically on frame completion, so downstream selectors never observe a partially updated frame.

## Interface
Parameters:
- DW, 8, byte width of every slot and of data_i
- TIMEOUT, 255, max idle cycles between writes inside a frame before abort; 0 disables the timeout

Ports:
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- start_i  in  1  one-cycle strobe: begin new frame, write index := 0
- wr_en_i  in  1  data_i valid this cycle
- data_i  in  DW  byte for current slot
- out_0 … out_8  out  DW each  published slot values (registered)
- sel_o  out  4  index of next slot to be written (0–8)
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse: frame published
- err_o  out  1  sticky protocol error; cleared by the next accepted start_i

## Operation
- Reset (rst_n_i = 0, immediate): state IDLE; out_0..out_8 = 0; shadow bank = 0; sel_o = 0; busy_o = 0; done_o = 0; err_o = 0; timeout counter = 0.
- FSM states are IDLE and LOAD.
- IDLE:
  - start_i → LOAD; sel_o := 0; err_o := 0.
  - wr_en_i without start_i → write dropped; err_o := 1.
  - start_i together with wr_en_i → start accepted, write dropped, no error.
- LOAD:
  - wr_en_i at sel_o = k (k < 8) → shadow[k] := data_i; sel_o := k+1; timeout counter := 0.
  - wr_en_i at sel_o = 8 → out_j := shadow[j] for j < 8 and out_8 := data_i, all on the same edge; done_o := 1 for one cycle; → IDLE; sel_o := 0.
  - start_i (with or without wr_en_i) → restart: sel_o := 0; shadow keeps stale bytes; the write is dropped; err_o := 1; stays in LOAD.
  - No wr_en_i → timeout counter increments. When the counter reaches TIMEOUT (TIMEOUT ≠ 0): → IDLE; sel_o := 0; err_o := 1; outputs untouched.
- Published outputs change only on frame completion. Aborted or restarted frames never reach out_*.
- busy_o = (state == LOAD), registered.

## Timing
- Throughput is one byte per cycle; back-to-back frames are allowed. A start_i in the cycle after the last write (state IDLE, done_o high) is accepted normally.
- Frame latency:
  - Last wr_en_i sampled at edge N.
  - out_* valid and done_o = 1 in cycle N..N+1.
  - done_o = 0 after edge N+1 unless another frame completes.
- Minimum frame: start_i at edge S, then writes at S+1 … S+9, done_o high after S+9.
- Timeout: TIMEOUT consecutive LOAD cycles without wr_en_i. The abort takes effect on the edge where the count reaches TIMEOUT.
- Reset mid-frame clears everything, including published outputs. No done_o pulse is generated.
- sel_o is registered and reflects the slot the next wr_en_i will fill.

## Structure
- Shared package: DW default, slot count constant N_SLOTS = 9, index width constant (4), FSM state encoding (IDLE, LOAD).
- Single module; the shadow bank is an internal array indexed by sel_o.
- One sub-module is natural: frame_timeout_cnt. It is a loadable down-counter with a clear and an expire flag, parameterised by TIMEOUT.

## Test plan
- Reset, then start_i, then 9 writes 8'h10..8'h18 → done_o pulses once after the 9th write; out_0 = 8'h10 … out_8 = 8'h18; err_o = 0; busy_o low.
- After the above, start_i plus 4 writes 8'hA0..8'hA3, then start_i again → out_* still 8'h10..8'h18; err_o = 1; sel_o = 0. A following full frame 8'h00..8'h08 publishes correctly and clears err_o at its start.
- wr_en_i = 1 with data 8'hFF in IDLE → no output change; err_o = 1; next start_i clears it.
- TIMEOUT = 4: start_i, 2 writes, then 4 idle cycles → busy_o drops; err_o = 1; outputs unchanged; sel_o = 0.
- Back-to-back: frame 1 (8'h01..8'h09) with start_i asserted the cycle after its last write, then frame 2 (8'h11..8'h19) → two done_o pulses; final out_* = 8'h11..8'h19.
- rst_n_i asserted asynchronously mid-frame (sel_o = 5) → all outputs 0 immediately, without waiting for a clock edge; no done_o pulse; the next frame loads cleanly.
